// File: rtl/shreg_mux_driver_pkg.sv
// Shared definitions for the shift-register / read-mux sequencer.
// FSM state encodings and fixed data/select widths.
package shreg_mux_driver_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shreg_mux_driver.sv
// Loads a byte serially (MSB first) into the downstream shift stage, sweeps the
// 8:1 read mux to recover it, and reports the read-back byte with a match flag.
module shreg_mux_driver
    import shreg_mux_driver_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             enable,
    output logic             S,
    output logic             A,
    output logic             B,
    output logic             C,
    input  logic             Z,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             match
);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   cnt;
    logic [WIDTH-1:0]   dreg;
    logic [WIDTH-2:0]   rb;
    logic [WIDTH-1:0]   rb_full;

    // The last mux bit is taken straight from Z on the final READ edge.
    assign rb_full = {Z, rb};

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (in_valid) state_nx = ST_SHIFT;
            ST_SHIFT: if (cnt == 3'd7) state_nx = ST_READ;
            ST_READ:  if (cnt == 3'd7) state_nx = ST_DONE;
            ST_DONE:  if (out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        enable    = 1'b0;
        S         = 1'b0;
        {A, B, C} = '0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE:  in_ready = 1'b1;
            ST_SHIFT: begin
                enable = 1'b1;
                S      = dreg[3'd7 - cnt];
            end
            ST_READ:  {A, B, C} = cnt;
            ST_DONE:  out_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dreg     <= '0;
            rb       <= '0;
            out_data <= '0;
            match    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dreg <= in_data;
                        cnt  <= '0;
                    end
                end
                ST_SHIFT: cnt <= cnt + 3'd1;
                ST_READ: begin
                    cnt <= cnt + 3'd1;
                    if (cnt != 3'd7) begin
                        rb[cnt] <= Z;
                    end else begin
                        out_data <= rb_full;
                        match    <= (rb_full == dreg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shreg_mux_driver.sv
// Bench for shreg_mux_driver against a behavioural shift/mux stage with
// optional stuck-at-0 bits; results are checked through a scoreboard queue.
module tb_shreg_mux_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       enable, S, A, B, C, Z;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       match;

    logic [7:0] q = '0;
    logic [7:0] stuck0 = '0;
    logic [7:0] qf;

    typedef struct packed { logic [7:0] data; logic m; } exp_t;
    exp_t        sb[$];
    int unsigned acc_q[$];
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    shreg_mux_driver dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .enable(enable), .S(S), .A(A), .B(B), .C(C),
        .Z(Z), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .match(match)
    );

    // Downstream stage model with injectable stuck-at-0 bits
    always @(posedge clk) if (enable) q <= {q[6:0], S};
    assign qf = q & ~stuck0;
    assign Z  = qf[{A, B, C}];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: push on accept, pop on output handshake
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back('{data: in_data & ~stuck0, m: ((in_data & ~stuck0) == in_data)});
                acc_q.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("match", match, e.m);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int unsigned base;
        bit ok;
        base = acc_q.size();
        ok = 0;
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk) #1;
            if (acc_q.size() > base) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk) #1;
            if (sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] pat;
        int unsigned base, t0;
        bit ok;

        // 1: reset state, then 8'hA5 shift pattern and latency
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_enable", enable, 0);
        chk("rst_S", S, 0);
        chk("rst_sel", {A, B, C}, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_match", match, 0);

        pat = 8'hA5;
        send(pat);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("shift_enable", enable, 1);
            chk("shift_S", S, pat[7-k]);
            chk("shift_sel", {A, B, C}, 0);
            @(posedge clk) #1;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("read_enable", enable, 0);
            chk("read_sel", {A, B, C}, k);
            chk("read_out_valid", out_valid, 0);
            @(posedge clk) #1;
        end
        @(negedge clk);
        chk("lat17_out_valid", out_valid, 1);
        drain();

        // 2: stuck-at-0 on Q[3]
        stuck0 = 8'h08;
        send(8'hFF);
        drain();
        @(posedge clk) #1;
        stuck0 = 8'h00;

        // 3: in_valid held through a transfer
        send(8'h12);
        in_valid = 1'b1;
        in_data  = 8'h3C;
        base = acc_q.size();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            chk("busy_in_ready", in_ready, 0);
            @(posedge clk) #1;
        end
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk) #1;
        in_valid = 1'b0;
        chk("held_accept", acc_q.size(), base + 1);
        drain();

        // 4: out_ready backpressure
        out_ready = 1'b0;
        send(8'h5A);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("out_valid_timeout", 0, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk) #1;
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_data", out_data, 8'h5A);
            chk("hold_match", match, 1);
        end
        @(posedge clk) #1;
        out_ready = 1'b1;
        @(posedge clk) #1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        drain();

        // 5: reset during SHIFT at cnt=4
        send(8'hC3);
        repeat (4) @(posedge clk) #1;
        @(negedge clk);
        chk("pre_rst_enable", enable, 1);
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_enable", enable, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        repeat (20) @(posedge clk);
        chk("abort_sb_empty", sb.size(), 0);
        send(8'h00);
        drain();

        // 6: back-to-back accepts with out_ready tied high
        base = acc_q.size();
        @(posedge clk) #1;
        in_valid = 1'b1;
        in_data  = 8'h01;
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk) #1;
            if (acc_q.size() == base + 1) in_data = 8'h80;
            if (acc_q.size() == base + 2) begin ok = 1; break; end
        end
        in_valid = 1'b0;
        if (!ok) chk("b2b_timeout", 0, 1);
        else chk("b2b_spacing", acc_q[base+1] - acc_q[base], 18);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
